snoop_bus_arbiter: RTL and testbench

Arbiter and transaction sequencer for the shared snooping bus of the MESI multiprocessor. It grants the bus to one of N processor caches at a time, broadcasts the winning command and address to all other caches, collects their snoop responses, and sequences any dirty-owner write-back and the main-memory access. It then returns fill data and a shared indication to the requester. It sits between the per-processor cache/MESI controllers and the single `memory` instance.

---
 rtl/snoop_bus_pkg.sv | 21 ++
 rtl/snoop_bus_arbiter_rr_arbiter.sv | 30 +++
 rtl/snoop_bus_arbiter.sv | 161 ++++++++++++++++
 tb/tb_snoop_bus_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snoop_bus_pkg.sv
// Shared definitions for the snooping bus arbiter: bus command codes,
// arbiter state encoding and default bus dimensions.
package snoop_bus_pkg;

  localparam int N_PROC_DEF = 3;
  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;

  localparam logic [1:0] BUS_RD   = 2'd1;
  localparam logic [1:0] BUS_RDX  = 2'd2;
  localparam logic [1:0] BUS_UPGR = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SNOOP = 3'd1,
    ST_WB    = 3'd2,
    ST_MEM   = 3'd3,
    ST_DONE  = 3'd4
  } arb_state_t;

endpackage

// File: rtl/snoop_bus_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first requester found scanning
// upward from prio (wrapping) wins; outputs one-hot grant and its index.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic [N-1:0] req,
  input  logic [1:0]   prio,
  output logic [N-1:0] gnt,
  output logic [1:0]   idx
);

  logic found;
  int   k;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(prio) + i) % N;
      if (!found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = 2'(k);
      end
    end
  end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Snooping bus arbiter / transaction sequencer (IDLE-SNOOP-WB/MEM-DONE).
// Optional statistics counters are enabled by SNOOP_BUS_ARB_STATS_EN.
module snoop_bus_arbiter
  import snoop_bus_pkg::*;
#(
  parameter int N_PROC = N_PROC_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [N_PROC-1:0]        req,
  input  logic [2*N_PROC-1:0]      req_cmd,
  input  logic [ADDR_W*N_PROC-1:0] req_addr,
  output logic [N_PROC-1:0]        gnt,
  output logic                     bus_valid,
  output logic [1:0]               bus_cmd,
  output logic [ADDR_W-1:0]        bus_addr,
  output logic [1:0]               bus_src,
  input  logic [N_PROC-1:0]        snoop_hit,
  input  logic [N_PROC-1:0]        snoop_dirty,
  input  logic [DATA_W*N_PROC-1:0] wb_data,
  output logic                     mem_rd,
  output logic                     mem_wr,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [N_PROC-1:0]        done,
  output logic [DATA_W-1:0]        fill_data,
  output logic                     fill_shared,
`ifdef SNOOP_BUS_ARB_STATS_EN
  output logic [15:0]              txn_count,
  output logic [15:0]              wb_count,
`endif
  output logic [2:0]               dbg_state
);

  arb_state_t          state;
  logic [1:0]          prio;
  logic [N_PROC-1:0]   pick_gnt;
  logic [1:0]          pick_idx;
  logic                shared_q;
  logic                from_mem_q;
  logic [DATA_W-1:0]   fill_q;
  logic [N_PROC-1:0]   other_hit;
  logic [N_PROC-1:0]   other_dirty;
  logic [1:0]          owner;
  logic [DATA_W-1:0]   wb_sel;

  rr_arbiter #(.N(N_PROC)) u_rr (
    .req  (req),
    .prio (prio),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );

  // gnt holds the winner's one-hot from SNOOP on, so it masks the winner out.
  assign other_hit   = snoop_hit & ~gnt;
  assign other_dirty = snoop_dirty & ~gnt;

  always_comb begin
    owner = '0;
    for (int i = N_PROC - 1; i >= 0; i--) begin
      if (other_dirty[i]) owner = 2'(i);
    end
  end

  assign wb_sel    = wb_data[DATA_W*owner +: DATA_W];
  assign mem_addr  = bus_addr;
  assign dbg_state = state;
  // Memory read data arrives in the DONE cycle itself, so it is forwarded.
  assign fill_data = from_mem_q ? mem_rdata : fill_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      prio        <= '0;
      gnt         <= '0;
      bus_valid   <= 1'b0;
      bus_cmd     <= '0;
      bus_addr    <= '0;
      bus_src     <= '0;
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_wdata   <= '0;
      done        <= '0;
      fill_shared <= 1'b0;
      shared_q    <= 1'b0;
      from_mem_q  <= 1'b0;
      fill_q      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) begin
            state     <= ST_SNOOP;
            gnt       <= pick_gnt;
            bus_src   <= pick_idx;
            bus_cmd   <= req_cmd[2*pick_idx +: 2];
            bus_addr  <= req_addr[ADDR_W*pick_idx +: ADDR_W];
            bus_valid <= 1'b1;
          end
        end
        ST_SNOOP: begin
          bus_valid <= 1'b0;
          shared_q  <= |other_hit;
          if (|other_dirty) begin
            state     <= ST_WB;
            mem_wr    <= 1'b1;
            mem_wdata <= wb_sel;
            fill_q    <= wb_sel;
          end else if (bus_cmd == BUS_UPGR) begin
            state       <= ST_DONE;
            done        <= gnt;
            fill_shared <= |other_hit;
            fill_q      <= '0;
            from_mem_q  <= 1'b0;
          end else begin
            state  <= ST_MEM;
            mem_rd <= 1'b1;
          end
        end
        ST_WB: begin
          state       <= ST_DONE;
          mem_wr      <= 1'b0;
          done        <= gnt;
          fill_shared <= shared_q;
          from_mem_q  <= 1'b0;
        end
        ST_MEM: begin
          state       <= ST_DONE;
          mem_rd      <= 1'b0;
          done        <= gnt;
          fill_shared <= shared_q;
          from_mem_q  <= 1'b1;
        end
        ST_DONE: begin
          state       <= ST_IDLE;
          done        <= '0;
          gnt         <= '0;
          fill_shared <= 1'b0;
          from_mem_q  <= 1'b0;
          prio        <= (bus_src == 2'(N_PROC - 1)) ? 2'd0 : bus_src + 2'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SNOOP_BUS_ARB_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      txn_count <= '0;
      wb_count  <= '0;
    end else begin
      if (state == ST_DONE && txn_count != 16'hFFFF) txn_count <= txn_count + 16'd1;
      if (state == ST_WB && wb_count != 16'hFFFF) wb_count <= wb_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed self-checking bench for snoop_bus_arbiter with a small
// registered memory model attached to the mem_* port.
module tb_snoop_bus_arbiter;

  localparam int N_PROC = 3;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  logic                     clock;
  logic                     reset_n;
  logic [N_PROC-1:0]        req;
  logic [2*N_PROC-1:0]      req_cmd;
  logic [ADDR_W*N_PROC-1:0] req_addr;
  logic [N_PROC-1:0]        gnt;
  logic                     bus_valid;
  logic [1:0]               bus_cmd;
  logic [ADDR_W-1:0]        bus_addr;
  logic [1:0]               bus_src;
  logic [N_PROC-1:0]        snoop_hit;
  logic [N_PROC-1:0]        snoop_dirty;
  logic [DATA_W*N_PROC-1:0] wb_data;
  logic                     mem_rd;
  logic                     mem_wr;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic [DATA_W-1:0]        mem_rdata;
  logic [N_PROC-1:0]        done;
  logic [DATA_W-1:0]        fill_data;
  logic                     fill_shared;
  logic [2:0]               dbg_state;
`ifdef SNOOP_BUS_ARB_STATS_EN
  logic [15:0]              txn_count;
  logic [15:0]              wb_count;
`endif

  int tests = 0;
  int fails = 0;
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  snoop_bus_arbiter #(.N_PROC(N_PROC), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .req_cmd(req_cmd),
    .req_addr(req_addr), .gnt(gnt), .bus_valid(bus_valid), .bus_cmd(bus_cmd),
    .bus_addr(bus_addr), .bus_src(bus_src), .snoop_hit(snoop_hit),
    .snoop_dirty(snoop_dirty), .wb_data(wb_data), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .done(done), .fill_data(fill_data),
    .fill_shared(fill_shared),
`ifdef SNOOP_BUS_ARB_STATS_EN
    .txn_count(txn_count), .wb_count(wb_count),
`endif
    .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Registered memory model: read data valid the cycle after mem_rd.
  always @(posedge clock) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
    if (mem_wr) mem[mem_addr] <= mem_wdata;
  end

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset;
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    apply_reset();
    tests++; if (dbg_state !== 3'd0) begin fails++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    tests++; if ({gnt, done, bus_valid, mem_rd, mem_wr, fill_shared} !== 10'd0) begin fails++;
      $display("FAIL reset_ctrl got gnt=%b done=%b bv=%b rd=%b wr=%b sh=%b exp all 0", gnt, done, bus_valid, mem_rd, mem_wr, fill_shared); end
    tests++; if ({bus_cmd, bus_addr, bus_src, mem_wdata, fill_data} !== 25'd0) begin fails++;
      $display("FAIL reset_data got cmd=%h addr=%h src=%h wd=%h fill=%h exp all 0", bus_cmd, bus_addr, bus_src, mem_wdata, fill_data); end
  endtask

  task automatic test_clean_read;
    req_cmd  = {2'd0, 2'd1, 2'd0};
    req_addr = {5'd0, 5'h0A, 5'd0};
    req = 3'b010;
    step();
    tests++; if (dbg_state !== 3'd1 || gnt !== 3'b010 || bus_valid !== 1'b1) begin fails++;
      $display("FAIL rd_snoop got st=%0d gnt=%b bv=%b exp st=1 gnt=010 bv=1", dbg_state, gnt, bus_valid); end
    tests++; if (bus_cmd !== 2'd1 || bus_addr !== 5'h0A || bus_src !== 2'd1) begin fails++;
      $display("FAIL rd_bus got cmd=%0d addr=%h src=%0d exp cmd=1 addr=0a src=1", bus_cmd, bus_addr, bus_src); end
    step();
    tests++; if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 5'h0A || bus_valid !== 1'b0) begin fails++;
      $display("FAIL rd_mem got rd=%b wr=%b addr=%h bv=%b exp rd=1 wr=0 addr=0a bv=0", mem_rd, mem_wr, mem_addr, bus_valid); end
    step();
    tests++; if (done !== 3'b010 || fill_data !== 8'h5A || fill_shared !== 1'b0 || mem_rd !== 1'b0) begin fails++;
      $display("FAIL rd_done got done=%b fill=%h sh=%b rd=%b exp done=010 fill=5a sh=0 rd=0", done, fill_data, fill_shared, mem_rd); end
    req = 3'b000;
    step();
    tests++; if (done !== 3'b000 || gnt !== 3'b000 || dbg_state !== 3'd0) begin fails++;
      $display("FAIL rd_idle got done=%b gnt=%b st=%0d exp 000 000 0", done, gnt, dbg_state); end
  endtask

  task automatic test_dirty_writeback;
    req_cmd  = {2'd0, 2'd0, 2'd2};
    req_addr = {5'd0, 5'd0, 5'h03};
    snoop_hit   = 3'b100;
    snoop_dirty = 3'b100;
    wb_data     = {8'hC3, 8'h00, 8'h11};
    req = 3'b001;
    step();
    tests++; if (gnt !== 3'b001 || bus_cmd !== 2'd2 || bus_src !== 2'd0) begin fails++;
      $display("FAIL wb_snoop got gnt=%b cmd=%0d src=%0d exp 001 2 0", gnt, bus_cmd, bus_src); end
    step();
    tests++; if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_wdata !== 8'hC3 || mem_addr !== 5'h03) begin fails++;
      $display("FAIL wb_write got wr=%b rd=%b wd=%h addr=%h exp 1 0 c3 03", mem_wr, mem_rd, mem_wdata, mem_addr); end
    step();
    tests++; if (done !== 3'b001 || fill_data !== 8'hC3 || fill_shared !== 1'b1 || mem_rd !== 1'b0 || mem_wr !== 1'b0) begin fails++;
      $display("FAIL wb_done got done=%b fill=%h sh=%b rd=%b wr=%b exp 001 c3 1 0 0", done, fill_data, fill_shared, mem_rd, mem_wr); end
    req = 3'b000;
    snoop_hit = '0; snoop_dirty = '0;
    step();
    tests++; if (mem[5'h03] !== 8'hC3) begin fails++; $display("FAIL wb_mem got=%h exp=c3", mem[5'h03]); end
  endtask

  task automatic test_upgrade;
    int rd_seen = 0;
    req_cmd  = {2'd3, 2'd0, 2'd0};
    req_addr = {5'h11, 5'd0, 5'd0};
    snoop_hit = 3'b001;
    req = 3'b100;
    step();
    tests++; if (gnt !== 3'b100 || bus_cmd !== 2'd3 || bus_addr !== 5'h11) begin fails++;
      $display("FAIL up_snoop got gnt=%b cmd=%0d addr=%h exp 100 3 11", gnt, bus_cmd, bus_addr); end
    if (mem_rd || mem_wr) rd_seen++;
    step();
    if (mem_rd || mem_wr) rd_seen++;
    tests++; if (done !== 3'b100 || fill_shared !== 1'b1 || fill_data !== 8'h00) begin fails++;
      $display("FAIL up_done got done=%b sh=%b fill=%h exp 100 1 00", done, fill_shared, fill_data); end
    req = 3'b000; snoop_hit = '0;
    step();
    if (mem_rd || mem_wr) rd_seen++;
    tests++; if (rd_seen !== 0) begin fails++; $display("FAIL up_nomem got=%0d mem strobes exp=0", rd_seen); end
  endtask

  task automatic test_round_robin;
    logic [N_PROC-1:0] exp_q[$];
    logic [N_PROC-1:0] exp_g;
    int multi = 0;
    int waited;
    exp_q = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
    req_cmd  = {2'd1, 2'd1, 2'd1};
    req_addr = {5'h02, 5'h01, 5'h00};
    reset_n = 1'b0;
    req = 3'b111;
    step();
    reset_n = 1'b1;
    while (exp_q.size() > 0) begin
      exp_g = exp_q.pop_front();
      waited = 0;
      do begin
        step();
        waited++;
        if ($countones(gnt) > 1) multi++;
        if (bus_valid && $countones(gnt) != 1) multi++;
      end while (done == '0 && waited < 10);
      tests++; if (done !== exp_g || gnt !== exp_g) begin fails++;
        $display("FAIL rr_order got done=%b gnt=%b exp=%b after %0d cycles", done, gnt, exp_g, waited); end
    end
    tests++; if (multi !== 0) begin fails++; $display("FAIL rr_onehot got=%0d violations exp=0", multi); end
    req = 3'b000;
    step();
  endtask

  task automatic test_reset_mid;
    int done_seen = 0;
    apply_reset();
    req_cmd  = {2'd1, 2'd1, 2'd1};
    req_addr = {5'h06, 5'h05, 5'h04};
    req = 3'b010;
    step(); step(); step();
    req = 3'b000;
    step();
    req = 3'b101;
    step();
    tests++; if (bus_src !== 2'd2 || gnt !== 3'b100) begin fails++;
      $display("FAIL rm_pick got src=%0d gnt=%b exp 2 100", bus_src, gnt); end
    step();
    tests++; if (mem_rd !== 1'b1 || dbg_state !== 3'd3) begin fails++;
      $display("FAIL rm_mem got rd=%b st=%0d exp 1 3", mem_rd, dbg_state); end
    reset_n = 1'b0;
    #1;
    tests++; if ({gnt, done, bus_valid, mem_rd, mem_wr, bus_addr, bus_src, fill_data, dbg_state} !== 30'd0) begin fails++;
      $display("FAIL rm_async got gnt=%b done=%b bv=%b rd=%b wr=%b addr=%h src=%0d fill=%h st=%0d exp all 0",
               gnt, done, bus_valid, mem_rd, mem_wr, bus_addr, bus_src, fill_data, dbg_state); end
    for (int i = 0; i < 2; i++) begin
      step();
      if (done != '0) done_seen++;
    end
    reset_n = 1'b1;
    step();
    tests++; if (bus_src !== 2'd0 || gnt !== 3'b001 || bus_addr !== 5'h04) begin fails++;
      $display("FAIL rm_rearb got src=%0d gnt=%b addr=%h exp 0 001 04", bus_src, gnt, bus_addr); end
    step();
    if (done != '0) done_seen++;
    step();
    tests++; if (done !== 3'b001) begin fails++; $display("FAIL rm_done got=%b exp=001", done); end
    tests++; if (done_seen !== 0) begin fails++; $display("FAIL rm_nodone got=%0d early done pulses exp=0", done_seen); end
    req = 3'b000;
    step();
  endtask

  initial begin
    reset_n = 1'b0;
    req = '0; req_cmd = '0; req_addr = '0;
    snoop_hit = '0; snoop_dirty = '0; wb_data = '0;
    mem_rdata = '0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'(i);
    mem[5'h0A] = 8'h5A;
    test_reset();
    test_clean_read();
    test_dirty_writeback();
`ifdef SNOOP_BUS_ARB_STATS_EN
    tests++; if (txn_count !== 16'd2 || wb_count !== 16'd1) begin fails++;
      $display("FAIL stats got txn=%0d wb=%0d exp 2 1", txn_count, wb_count); end
`endif
    test_upgrade();
    test_round_robin();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=no_finish exp=finish");
    $fatal(1, "timeout");
  end

endmodule
